// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture
//   Sweeps all 16 input combinations of a 4-input gate under test, waits
//   SETTLE_CYCLES per row, samples the gate output, and assembles the captured
//   truth table (row 0 in the MSB, matching hex truth-table notation).
//
//   Optional feature macro: TT_SWEEP_COMPARE_EN
//     defined   -> match is registered in DONE as (tt == EXPECTED_TT)
//     undefined -> no compare logic, match is constant 0
//
//   Parameters:
//     SETTLE_CYCLES  wait cycles per row before sampling (0..255)
//     EXPECTED_TT    reference truth table for the compare
//
//   Ports:
//     clk       in   single clock, rising edge
//     rst_n     in   synchronous active-low reset
//     start     in   sweep request pulse (ignored while busy)
//     abort     in   cancels a running sweep, zeroes tt, no done
//     in_vec    out  [3:0] drive to gate; in_vec[3] -> _0 ... in_vec[0] -> _3
//     gate_out  in   gate under test output (_4)
//     busy      out  high while a sweep runs
//     done      out  one-cycle completion pulse
//     tt        out  [15:0] captured truth table, held in IDLE
//     match     out  tt equals EXPECTED_TT (feature macro only)
module tt_sweep_capture #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED_TT   = 16'h47FD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  in_vec,
   input  logic        gate_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic        match
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   // Last settle count value before moving to SAMPLE; unused when SETTLE_CYCLES=0.
   localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
   // Each row starts in SETTLE, or directly in SAMPLE when no settling is wanted.
   localparam state_t ROW_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   state_t     state;
   logic [3:0] row;
   logic [7:0] settle_cnt;

`ifdef TT_SWEEP_COMPARE_EN
   logic match_q;
   assign match = match_q;
`else
   assign match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         row        <= '0;
         settle_cnt <= '0;
         in_vec     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         tt         <= '0;
`ifdef TT_SWEEP_COMPARE_EN
         match_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            // Abort discards the partial sweep entirely, including the done of DONE.
            state      <= IDLE;
            row        <= '0;
            settle_cnt <= '0;
            in_vec     <= '0;
            busy       <= 1'b0;
            tt         <= '0;
`ifdef TT_SWEEP_COMPARE_EN
            match_q    <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  // abort in the same cycle as start suppresses the sweep
                  if (start && !abort) begin
                     tt         <= '0;
                     row        <= '0;
                     settle_cnt <= '0;
                     in_vec     <= '0;
                     busy       <= 1'b1;
                     state      <= ROW_ENTRY;
`ifdef TT_SWEEP_COMPARE_EN
                     match_q    <= 1'b0;
`endif
                  end
               end
               SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     settle_cnt <= '0;
                     state      <= SAMPLE;
                  end else begin
                     settle_cnt <= settle_cnt + 8'd1;
                  end
               end
               SAMPLE: begin
                  tt[4'd15 - row] <= gate_out;
                  if (row == 4'd15) begin
                     in_vec <= '0;
                     state  <= DONE;
                  end else begin
                     row    <= row + 4'd1;
                     in_vec <= row + 4'd1;
                     state  <= ROW_ENTRY;
                  end
               end
               DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  row   <= '0;
                  state <= IDLE;
`ifdef TT_SWEEP_COMPARE_EN
                  match_q <= (tt == EXPECTED_TT);
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Testbench for tt_sweep_capture: a settling instance (SETTLE_CYCLES=2) driven by a
// table-lookup gate model, and a fast instance (SETTLE_CYCLES=0) with gate_out tied 1.
module tb_tt_sweep_capture;

   localparam logic [15:0] REF_TT = 16'h47FD;
`ifdef TT_SWEEP_COMPARE_EN
   localparam logic MATCH_ON = 1'b1;
`else
   localparam logic MATCH_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, start0, abort0;
   logic [15:0] gate_tt;
   logic [3:0]  in_vec, in_vec0;
   logic        gate_out, gate_one;
   logic        busy, done, match, busy0, done0, match0;
   logic [15:0] tt, tt0;

   assign gate_out = gate_tt[4'd15 - in_vec];
   assign gate_one = 1'b1;

   tt_sweep_capture #(.SETTLE_CYCLES(2), .EXPECTED_TT(REF_TT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_vec(in_vec),
      .gate_out(gate_out), .busy(busy), .done(done), .tt(tt), .match(match));

   tt_sweep_capture #(.SETTLE_CYCLES(0), .EXPECTED_TT(REF_TT)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .in_vec(in_vec0),
      .gate_out(gate_one), .busy(busy0), .done(done0), .tt(tt0), .match(match0));

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] tt;
      logic        match;
      int unsigned when;
   } exp_t;

   exp_t sb[$];
   exp_t sb0[$];
   exp_t m_e, m_e0;

   // Scoreboard monitors: every done must correspond to a pushed expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending sweep", cyc);
         end else begin
            m_e = sb.pop_front();
            checks += 3;
            if (tt !== m_e.tt) begin
               errors++; $display("FAIL done_tt: got %h, required %h", tt, m_e.tt);
            end
            if (match !== m_e.match) begin
               errors++; $display("FAIL done_match: got %b, required %b", match, m_e.match);
            end
            if (cyc !== m_e.when) begin
               errors++; $display("FAIL done_time: got cycle %0d, required %0d", cyc, m_e.when);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         checks++;
         if (sb0.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done0: done0=1 at cycle %0d, required no pending sweep", cyc);
         end else begin
            m_e0 = sb0.pop_front();
            checks += 3;
            if (tt0 !== m_e0.tt) begin
               errors++; $display("FAIL done0_tt: got %h, required %h", tt0, m_e0.tt);
            end
            if (match0 !== m_e0.match) begin
               errors++; $display("FAIL done0_match: got %b, required %b", match0, m_e0.match);
            end
            if (cyc !== m_e0.when) begin
               errors++; $display("FAIL done0_time: got cycle %0d, required %0d", cyc, m_e0.when);
            end
         end
      end
   end

   task automatic wait_done(input bit fast, input int bound, input string name);
      int n = 0;
      while (((fast ? done0 : done) !== 1'b1) && n < bound) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((fast ? done0 : done) !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, bound);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; start0 = 1'b1; abort = 1'b0; abort0 = 1'b0; gate_tt = REF_TT;
      repeat (3) @(negedge clk);
      checks += 2;
      if ({in_vec, busy, done, tt, match} !== 23'd0) begin
         errors++; $display("FAIL reset_state: got %h, required 0", {in_vec, busy, done, tt, match});
      end
      if ({in_vec0, busy0, done0, tt0, match0} !== 23'd0) begin
         errors++; $display("FAIL reset_state0: got %h, required 0", {in_vec0, busy0, done0, tt0, match0});
      end
      rst_n = 1'b1; start = 1'b0; start0 = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, busy0} !== 2'b00) begin
         errors++; $display("FAIL reset_start_ignored: busy=%b%b, required 00", busy, busy0);
      end
   endtask

   task automatic test_sweep(input logic [15:0] pat, input string name);
      gate_tt = pat;
      start = 1'b1;
      sb.push_back('{tt: pat, match: MATCH_ON && (pat == REF_TT), when: cyc + 1 + 49});
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (in_vec !== 4'(k / 3) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_row: k=%0d in_vec=%0d busy=%b, required in_vec=%0d busy=1",
                     name, k, in_vec, busy, k / 3);
         end
         @(negedge clk);
      end
      wait_done(1'b0, 10, name);
      repeat (5) @(negedge clk);
      checks += 2;
      if (tt !== pat || match !== (MATCH_ON && (pat == REF_TT))) begin
         errors++; $display("FAIL %s_hold: tt=%h match=%b, required tt=%h", name, tt, match, pat);
      end
      if ({busy, done, in_vec} !== 6'd0) begin
         errors++; $display("FAIL %s_idle: busy=%b done=%b in_vec=%0d, required 0", name, busy, done, in_vec);
      end
   endtask

   task automatic test_fast();
      start0 = 1'b1;
      sb0.push_back('{tt: 16'hFFFF, match: 1'b0, when: cyc + 1 + 17});
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (in_vec0 !== 4'(k) || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL fast_row: k=%0d in_vec0=%0d busy0=%b, required in_vec0=%0d busy0=1",
                     k, in_vec0, busy0, k);
         end
         @(negedge clk);
      end
      wait_done(1'b1, 10, "fast");
      @(negedge clk);
      checks++;
      if (tt0 !== 16'hFFFF || match0 !== 1'b0 || busy0 !== 1'b0 || in_vec0 !== 4'd0) begin
         errors++; $display("FAIL fast_hold: tt0=%h match0=%b busy0=%b, required FFFF 0 0", tt0, match0, busy0);
      end
   endtask

   task automatic test_abort();
      gate_tt = REF_TT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks += 2;
      if ({busy, done, in_vec} !== 6'd0) begin
         errors++; $display("FAIL abort_ctrl: busy=%b done=%b in_vec=%0d, required 0", busy, done, in_vec);
      end
      if (tt !== 16'h0000 || match !== 1'b0) begin
         errors++; $display("FAIL abort_tt: tt=%h match=%b, required 0000 0", tt, match);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_stays_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_start_abort_same();
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_vec !== 4'd0) begin
         errors++; $display("FAIL start_abort_same: busy=%b in_vec=%0d, required 0", busy, in_vec);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      gate_tt = REF_TT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({in_vec, busy, done, tt, match} !== 23'd0) begin
         errors++; $display("FAIL reset_mid: got %h, required 0", {in_vec, busy, done, tt, match});
      end
      repeat (2) @(negedge clk);
      test_sweep(16'hA5C3, "after_reset");
   endtask

   task automatic test_back_to_back();
      int n = 0;
      gate_tt = REF_TT;
      sb.push_back('{tt: REF_TT, match: MATCH_ON, when: cyc + 1 + 49});
      start = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL back_to_back_timeout: done=0 after %0d cycles, required 1", n);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tt !== REF_TT) begin
         errors++; $display("FAIL back_to_back_idle: busy=%b tt=%h, required 0 %h", busy, tt, REF_TT);
      end
   endtask

   initial begin
      test_reset();
      test_sweep(REF_TT, "sweep_ref");
      test_fast();
      test_abort();
      test_start_abort_same();
      test_reset_mid();
      test_sweep(16'h0001, "sweep_lsb");
      test_back_to_back();
      repeat (5) @(negedge clk);
      checks++;
      if (sb.size() != 0 || sb0.size() != 0) begin
         errors++; $display("FAIL pending_sweeps: got %0d/%0d outstanding, required 0/0", sb.size(), sb0.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
